// File: rtl/fifo_pkg.sv
// fifo_pkg
//    Shared definitions for the activation FIFO. The phase codes below are
//    exported on the FIFO's `state` port. The cycle-breakdown profiler decodes
//    the same values, so these codes must stay fixed.
package fifo_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_CALC = ST_CALC,
      S_DONE = ST_DONE
   } fifo_state_e;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
//    DEPTH x WIDTH register array with one write port and a combinational
//    read port. The contents are intentionally not reset.
//    Ports:
//       clk    - clock; the write occurs on the rising edge
//       we     - write enable
//       waddr  - write address
//       wdata  - write data
//       raddr  - read address
//       rdata  - read data, mem[raddr], combinational
module fifo_mem #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Storage write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/activation_fifo.sv
// activation_fifo
//    Single-batch buffer between two backpropagation layer stages. The FIFO
//    collects BATCH words from the producer and then drains them to the
//    consumer. It exports its phase (IDLE/CALC/DONE) and a print strobe that
//    pulses once every PRINT_EVERY completed batches.
//    Ports:
//       clk        - clock, all logic on the rising edge
//       rst        - synchronous active-low reset
//       in_valid   - producer word valid
//       in_ready   - FIFO accepts a word (IDLE/CALC)
//       in_data    - producer word
//       out_valid  - word available to consumer (DONE)
//       out_ready  - consumer accepts word
//       out_data   - head word mem[rd_ptr]
//       state      - registered phase code from fifo_pkg
//       print      - one-cycle strobe after every PRINT_EVERY-th drain
//       level      - words currently stored
module activation_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int DEPTH       = 8,
   parameter int BATCH       = 8,
   parameter int PRINT_EVERY = 4,
   localparam int LW         = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       state,
   output logic             print,
   output logic [LW-1:0]    level
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = (PRINT_EVERY > 1) ? $clog2(PRINT_EVERY) : 1;

   fifo_state_e      state_r,  state_nxt_s;
   logic [AW-1:0]    wr_ptr_r, wr_ptr_nxt_s;
   logic [AW-1:0]    rd_ptr_r, rd_ptr_nxt_s;
   logic [LW-1:0]    wr_cnt_r, wr_cnt_nxt_s;
   logic [LW-1:0]    rd_cnt_r, rd_cnt_nxt_s;
   logic [PW-1:0]    bcnt_r,   bcnt_nxt_s;
   logic             print_r,  print_nxt_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [LW-1:0]    level_r;
   logic             wr_fire_s;
   logic             rd_fire_s;

   // In DONE, in_ready is low. In IDLE/CALC, out_valid is low.
   // As a result, the two transfers are mutually exclusive by construction.
   assign wr_fire_s = in_valid  & in_ready_r;
   assign rd_fire_s = out_ready & out_valid_r;

   // Next-state, pointer, count and batch-counter logic
   always_comb begin
      state_nxt_s  = state_r;
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      wr_cnt_nxt_s = wr_cnt_r;
      rd_cnt_nxt_s = rd_cnt_r;
      bcnt_nxt_s   = bcnt_r;
      print_nxt_s  = 1'b0;
      case (state_r)
         S_IDLE, S_CALC: begin
            if (wr_fire_s) begin
               wr_ptr_nxt_s = wr_ptr_r + AW'(1);
               wr_cnt_nxt_s = wr_cnt_r + LW'(1);
               if (wr_cnt_r == LW'(BATCH - 1)) begin
                  state_nxt_s = S_DONE;
               end else begin
                  state_nxt_s = S_CALC;
               end
            end else begin
               state_nxt_s = state_r;
            end
         end
         S_DONE: begin
            if (rd_fire_s) begin
               rd_ptr_nxt_s = rd_ptr_r + AW'(1);
               if (rd_cnt_r == LW'(BATCH - 1)) begin
                  // Last word of the batch: the counts clear on the entry to IDLE.
                  state_nxt_s  = S_IDLE;
                  wr_cnt_nxt_s = LW'(0);
                  rd_cnt_nxt_s = LW'(0);
                  if (bcnt_r == PW'(PRINT_EVERY - 1)) begin
                     bcnt_nxt_s  = PW'(0);
                     print_nxt_s = 1'b1;
                  end else begin
                     bcnt_nxt_s  = bcnt_r + PW'(1);
                  end
               end else begin
                  rd_cnt_nxt_s = rd_cnt_r + LW'(1);
               end
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // Control registers. All outputs are registered from next-state values,
   // so they stay stable for the whole cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= S_IDLE;
         wr_ptr_r    <= AW'(0);
         rd_ptr_r    <= AW'(0);
         wr_cnt_r    <= LW'(0);
         rd_cnt_r    <= LW'(0);
         bcnt_r      <= PW'(0);
         print_r     <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         level_r     <= LW'(0);
      end else begin
         state_r     <= state_nxt_s;
         wr_ptr_r    <= wr_ptr_nxt_s;
         rd_ptr_r    <= rd_ptr_nxt_s;
         wr_cnt_r    <= wr_cnt_nxt_s;
         rd_cnt_r    <= rd_cnt_nxt_s;
         bcnt_r      <= bcnt_nxt_s;
         print_r     <= print_nxt_s;
         in_ready_r  <= (state_nxt_s != S_DONE);
         out_valid_r <= (state_nxt_s == S_DONE);
         level_r     <= wr_cnt_nxt_s - rd_cnt_nxt_s;
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_fire_s),
      .waddr (wr_ptr_r),
      .wdata (in_data),
      .raddr (rd_ptr_r),
      .rdata (out_data)
   );

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign state     = state_r;
   assign print     = print_r;
   assign level     = level_r;

endmodule

// File: tb/tb_activation_fifo.sv
// tb_activation_fifo
//    Directed self-checking bench. Instance a uses BATCH=8/DEPTH=8/PRINT_EVERY=4.
//    Instance b uses the edge configuration BATCH=1/DEPTH=2.
module tb_activation_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_print;
   logic [15:0] a_in_data = 16'h0, a_out_data;
   logic [1:0]  a_state;
   logic [3:0]  a_level;

   logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_print;
   logic [15:0] b_in_data = 16'h0, b_out_data;
   logic [1:0]  b_state;
   logic [1:0]  b_level;

   int ntests = 0;
   int nfail  = 0;
   int print_cnt = 0;
   int batches = 0;

   always #5 clk = ~clk;

   activation_fifo #(.WIDTH(16), .DEPTH(8), .BATCH(8), .PRINT_EVERY(4)) u_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .state(a_state), .print(a_print), .level(a_level)
   );

   activation_fifo #(.WIDTH(16), .DEPTH(2), .BATCH(1), .PRINT_EVERY(4)) u_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .state(b_state), .print(b_print), .level(b_level)
   );

   // Count print pulses of instance a, sampled mid-cycle
   always @(negedge clk) begin
      if (a_print) print_cnt <= print_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Write 8 consecutive words base..base+7 with no gaps
   task automatic fill8(input logic [15:0] base);
      for (int i = 0; i < 8; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = base + 16'(i);
         step();
      end
      a_in_valid = 1'b0;
      chk("fill_state_done", a_state, 32'd2);
      chk("fill_in_ready", a_in_ready, 32'd0);
   endtask

   // Drain the remaining n words expecting base..base+n-1, then check idle/print
   task automatic drain(input logic [15:0] base, input int n);
      a_out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         chk("drain_data", a_out_data, 32'(base + 16'(i)));
         step();
      end
      a_out_ready = 1'b0;
      batches++;
      chk("drain_state_idle", a_state, 32'd0);
      chk("drain_in_ready", a_in_ready, 32'd1);
      chk("drain_print", a_print, (batches % 4 == 0) ? 32'd1 : 32'd0);
      step();
      chk("print_width", a_print, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset held for two cycles
      step();
      step();
      chk("rst_state", a_state, 32'd0);
      chk("rst_in_ready", a_in_ready, 32'd1);
      chk("rst_out_valid", a_out_valid, 32'd0);
      chk("rst_level", a_level, 32'd0);
      chk("rst_print", a_print, 32'd0);
      chk("rst_b_state", b_state, 32'd0);
      rst = 1'b1;
      step();

      // Full batch 0x0001..0x0008: state goes to CALC after the first write and to DONE after the eighth
      for (int i = 0; i < 8; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = 16'(i + 1);
         step();
         chk("full_state", a_state, (i < 7) ? 32'd1 : 32'd2);
         chk("full_level", a_level, 32'(i + 1));
      end
      a_in_valid = 1'b0;
      chk("full_out_valid", a_out_valid, 32'd1);
      chk("full_in_ready", a_in_ready, 32'd0);
      drain(16'h0001, 8);

      // Back-pressure with out_ready 1,0,0,1, and in_valid held high in DONE
      fill8(16'h0010);
      a_in_valid  = 1'b1;
      a_in_data   = 16'hFFFF;
      a_out_ready = 1'b1;
      chk("bp_data0", a_out_data, 32'h0010);
      step();
      chk("bp_level1", a_level, 32'd7);
      a_out_ready = 1'b0;
      chk("bp_data1", a_out_data, 32'h0011);
      step();
      chk("bp_hold_level", a_level, 32'd7);
      chk("bp_hold_data", a_out_data, 32'h0011);
      step();
      chk("bp_hold_level2", a_level, 32'd7);
      chk("bp_hold_data2", a_out_data, 32'h0011);
      a_out_ready = 1'b1;
      step();
      chk("bp_level2", a_level, 32'd6);
      a_in_valid = 1'b0;
      drain(16'h0012, 6);

      // Reset mid-batch after 5 of 8 writes
      for (int i = 0; i < 5; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = 16'h0050 + 16'(i);
         step();
      end
      a_in_valid = 1'b0;
      chk("mid_level5", a_level, 32'd5);
      chk("mid_state_calc", a_state, 32'd1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      batches = 0;
      chk("mid_rst_level", a_level, 32'd0);
      chk("mid_rst_state", a_state, 32'd0);
      chk("mid_rst_in_ready", a_in_ready, 32'd1);

      // Fresh batch 0xA0..0xA7, then 7 more batches. Print is expected after the 4th and 8th batch.
      print_cnt = 0;
      fill8(16'h00A0);
      drain(16'h00A0, 8);
      for (int b = 1; b < 8; b++) begin
         fill8(16'(b * 16'h0100));
         drain(16'(b * 16'h0100), 8);
      end
      chk("print_count", print_cnt, 32'd2);

      // Edge config BATCH=1, DEPTH=2: each write goes directly from IDLE to DONE, and the pointers wrap
      for (int i = 0; i < 3; i++) begin
         b_in_valid = 1'b1;
         b_in_data  = 16'h00B0 + 16'(i);
         step();
         b_in_valid = 1'b0;
         chk("b1_state_done", b_state, 32'd2);
         chk("b1_in_ready", b_in_ready, 32'd0);
         chk("b1_level", b_level, 32'd1);
         b_out_ready = 1'b1;
         chk("b1_data", b_out_data, 32'h00B0 + 32'(i));
         step();
         b_out_ready = 1'b0;
         chk("b1_state_idle", b_state, 32'd0);
         chk("b1_level0", b_level, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
